// File: rtl/ddr5_cmd_pkg.sv
// Shared types and CA opcode constants for the DDR5 command encoder.
package ddr5_cmd_pkg;

    localparam int CA_W = 14;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4,
        CMD_REF = 3'd5
    } cmd_type_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PH1,
        ST_PH2
    } state_e;

    typedef struct packed {
        cmd_type_e   cmd_type;
        logic [2:0]  bg;
        logic [1:0]  ba;
        logic [15:0] row;
        logic [9:0]  col;
    } cmd_req_t;

    // ACT only owns CA[1:0]; its upper opcode bits carry row address.
    localparam logic [4:0] OP_ACT = 5'b00000;
    localparam logic [4:0] OP_RD  = 5'b11101;
    localparam logic [4:0] OP_WR  = 5'b01101;
    localparam logic [4:0] OP_PRE = 5'b11011;
    localparam logic [4:0] OP_REF = 5'b10011;

    function automatic logic is_legal(input logic [2:0] t);
        return (t >= 3'd1) && (t <= 3'd5);
    endfunction

    function automatic logic is_two_phase(input cmd_type_e t);
        return (t == CMD_ACT) || (t == CMD_RD) || (t == CMD_WR);
    endfunction

endpackage

// File: rtl/ddr5_cmd_encoder_if.sv
// Scheduler-to-encoder command handshake.
interface ddr5_cmd_encoder_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_type;
    logic [2:0]  cmd_bg;
    logic [1:0]  cmd_ba;
    logic [15:0] cmd_row;
    logic [9:0]  cmd_col;

    modport master (
        output cmd_valid, cmd_type, cmd_bg, cmd_ba, cmd_row, cmd_col,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_type, cmd_bg, cmd_ba, cmd_row, cmd_col,
        output cmd_ready
    );

endinterface

// File: rtl/ddr5_cmd_encoder.sv
// DDR5 CS_n/CA command encoder: one- or two-phase commands, each phase held DRAM_CLK_DIV clocks.
// Define DDR5_CMD_TRACE_EN to print a trace line at every PH1 entry.
module ddr5_cmd_encoder
    import ddr5_cmd_pkg::*;
#(
    parameter int DRAM_CLK_DIV = 2,
    parameter int CNT_W        = 32
) (
    input  logic                clock,
    input  logic                reset_n,
    ddr5_cmd_encoder_if.slave   req,
    output logic                cs_n,
    output logic [CA_W-1:0]     ca,
    output logic                cmd_issued,
    output logic                err_illegal,
    output logic [CNT_W-1:0]    issue_count
);

    localparam logic [2:0] PH_LAST = 3'(DRAM_CLK_DIV - 1);

    state_e             state_q, state_d;
    logic [2:0]         phase_q, phase_d;
    cmd_req_t           cmd_q, cmd_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ready;
    logic               accept;
    logic               accept_legal;
    logic               final_phase;
    logic               unused_col;

    assign unused_col = ^cmd_q.col[1:0];

    // The command may be handed back in the last cycle of its final phase so the next PH1 follows with no bubble.
    assign final_phase  = (state_q == ST_PH2) ||
                          ((state_q == ST_PH1) && !is_two_phase(cmd_q.cmd_type));
    assign ready        = (state_q == ST_IDLE) || (final_phase && (phase_q == 3'd0));
    assign accept       = req.cmd_valid && ready;
    assign accept_legal = accept && is_legal(req.cmd_type);

    always_comb begin
        // NOTE: every comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
        state_d = state_q;
        phase_d = phase_q;
        cmd_d   = cmd_q;
        err_d   = accept && !is_legal(req.cmd_type);
        count_d = count_q + CNT_W'(accept_legal);

        case (state_q)
            ST_PH1: begin
                if (phase_q != 3'd0) begin
                    phase_d = phase_q - 3'd1;
                end else if (is_two_phase(cmd_q.cmd_type)) begin
                    state_d = ST_PH2;
                    phase_d = PH_LAST;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PH2: begin
                if (phase_q != 3'd0) phase_d = phase_q - 3'd1;
                else                 state_d = ST_IDLE;
            end
            default: ;
        endcase

        if (accept_legal) begin
            state_d      = ST_PH1;
            phase_d      = PH_LAST;
            cmd_d.cmd_type = cmd_type_e'(req.cmd_type);
            cmd_d.bg     = req.cmd_bg;
            cmd_d.ba     = req.cmd_ba;
            cmd_d.row    = req.cmd_row;
            cmd_d.col    = req.cmd_col;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            phase_q <= '0;
            cmd_q   <= '0;
            err_q   <= 1'b0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            phase_q <= phase_d;
            cmd_q   <= cmd_d;
            err_q   <= err_d;
            count_q <= count_d;
        end
    end

    // Bus is decoded from state, so an async reset deselects it without waiting for an edge.
    always_comb begin
        cs_n = 1'b1;
        ca   = '0;
        case (state_q)
            ST_PH1: begin
                cs_n = 1'b0;
                case (cmd_q.cmd_type)
                    CMD_ACT: begin
                        ca[1:0]  = OP_ACT[1:0];
                        ca[5:2]  = cmd_q.row[3:0];
                        ca[7:6]  = cmd_q.ba;
                        ca[10:8] = cmd_q.bg;
                    end
                    CMD_RD, CMD_WR: begin
                        ca[4:0]  = (cmd_q.cmd_type == CMD_RD) ? OP_RD : OP_WR;
                        ca[5]    = 1'b1;
                        ca[7:6]  = cmd_q.ba;
                        ca[10:8] = cmd_q.bg;
                    end
                    CMD_PRE: begin
                        ca[4:0]  = OP_PRE;
                        ca[7:6]  = cmd_q.ba;
                        ca[10:8] = cmd_q.bg;
                    end
                    CMD_REF: ca[4:0] = OP_REF;
                    default: ;
                endcase
            end
            ST_PH2: begin
                case (cmd_q.cmd_type)
                    CMD_ACT: ca[11:0] = cmd_q.row[15:4];
                    CMD_RD, CMD_WR: begin
                        ca[7:0] = cmd_q.col[9:2];
                        ca[9]   = 1'b1;
                        ca[10]  = (cmd_q.cmd_type == CMD_WR);
                    end
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    assign req.cmd_ready = ready;
    assign cmd_issued    = (state_q == ST_PH1) && (phase_q == PH_LAST);
    assign err_illegal   = err_q;
    assign issue_count   = count_q;

`ifdef DDR5_CMD_TRACE_EN
    logic [31:0] cycle_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) cycle_q <= '0;
        else          cycle_q <= cycle_q + 32'd1;
    end

    always_ff @(posedge clock) begin
        if (reset_n && accept_legal) begin
            case (cmd_type_e'(req.cmd_type))
                CMD_ACT: $display("%0d ACT %0d %0d %h", cycle_q + 32'd1, req.cmd_bg, req.cmd_ba, req.cmd_row);
                CMD_RD:  $display("%0d RD %0d %0d %h", cycle_q + 32'd1, req.cmd_bg, req.cmd_ba, req.cmd_col);
                CMD_WR:  $display("%0d WR %0d %0d %h", cycle_q + 32'd1, req.cmd_bg, req.cmd_ba, req.cmd_col);
                CMD_PRE: $display("%0d PRE %0d %0d", cycle_q + 32'd1, req.cmd_bg, req.cmd_ba);
                default: $display("%0d REF %0d %0d", cycle_q + 32'd1, req.cmd_bg, req.cmd_ba);
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_ddr5_cmd_encoder.sv
// Directed bench for ddr5_cmd_encoder at DRAM_CLK_DIV=2; cycle k is the interval after accept edge k.
module tb_ddr5_cmd_encoder;
    import ddr5_cmd_pkg::*;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        cs_n;
    logic [13:0] ca;
    logic        cmd_issued;
    logic        err_illegal;
    logic [31:0] issue_count;
    int          checks = 0;
    int          errors = 0;

    ddr5_cmd_encoder_if bus ();

    ddr5_cmd_encoder #(.DRAM_CLK_DIV(2), .CNT_W(32)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .req         (bus),
        .cs_n        (cs_n),
        .ca          (ca),
        .cmd_issued  (cmd_issued),
        .err_illegal (err_illegal),
        .issue_count (issue_count)
    );

    always #5 clock = ~clock;

    task automatic next_cycle();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic drive(input logic v, input logic [2:0] t, input logic [2:0] bg,
                         input logic [1:0] ba, input logic [15:0] row, input logic [9:0] col);
        bus.cmd_valid = v;
        bus.cmd_type  = t;
        bus.cmd_bg    = bg;
        bus.cmd_ba    = ba;
        bus.cmd_row   = row;
        bus.cmd_col   = col;
    endtask

    task automatic do_reset();
        drive(1'b0, 3'd0, 3'd0, 2'd0, 16'd0, 10'd0);
        reset_n = 1'b0;
        next_cycle();
        next_cycle();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            checks++; if (cs_n !== 1'b1) begin errors++; $display("FAIL reset_cs_n c%0d: got %b expected 1", c, cs_n); end
            checks++; if (ca !== 14'h0) begin errors++; $display("FAIL reset_ca c%0d: got %h expected 0000", c, ca); end
            checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL reset_ready c%0d: got %b expected 1", c, bus.cmd_ready); end
            checks++; if (issue_count !== 32'd0) begin errors++; $display("FAIL reset_count c%0d: got %0d expected 0", c, issue_count); end
            checks++; if (cmd_issued !== 1'b0 || err_illegal !== 1'b0) begin errors++; $display("FAIL reset_pulses c%0d: got %b%b expected 00", c, cmd_issued, err_illegal); end
            next_cycle();
        end
    endtask

    task automatic test_act();
        logic        exp_cs;
        logic [13:0] exp_ca;
        do_reset();
        drive(1'b1, CMD_ACT, 3'd5, 2'd2, 16'hABCD, 10'd0);
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL act_ready_c0: got %b expected 1", bus.cmd_ready); end
        next_cycle();
        drive(1'b0, CMD_RD, 3'd0, 2'd0, 16'h0000, 10'd0);
        for (int c = 1; c <= 5; c++) begin
            exp_cs = (c > 2);
            exp_ca = (c <= 2) ? 14'h05B4 : (c <= 4) ? 14'h0ABC : 14'h0000;
            checks++; if (cs_n !== exp_cs) begin errors++; $display("FAIL act_cs_n c%0d: got %b expected %b", c, cs_n, exp_cs); end
            checks++; if (ca !== exp_ca) begin errors++; $display("FAIL act_ca c%0d: got %h expected %h", c, ca, exp_ca); end
            checks++; if (cmd_issued !== (c == 1)) begin errors++; $display("FAIL act_issued c%0d: got %b expected %b", c, cmd_issued, (c == 1)); end
            checks++; if (issue_count !== 32'd1) begin errors++; $display("FAIL act_count c%0d: got %0d expected 1", c, issue_count); end
            checks++; if (bus.cmd_ready !== (c >= 4)) begin errors++; $display("FAIL act_ready c%0d: got %b expected %b", c, bus.cmd_ready, (c >= 4)); end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        logic        exp_cs;
        logic [13:0] exp_ca;
        logic        exp_ready;
        logic [31:0] exp_cnt;
        do_reset();
        drive(1'b1, CMD_WR, 3'd1, 2'd3, 16'd0, 10'h3F4);
        next_cycle();
        drive(1'b1, CMD_RD, 3'd1, 2'd3, 16'd0, 10'h3F4);
        for (int c = 1; c <= 9; c++) begin
            exp_cs    = !((c <= 2) || (c == 5) || (c == 6));
            exp_ca    = (c <= 2) ? 14'h01ED : (c <= 4) ? 14'h06FD :
                        (c <= 6) ? 14'h01FD : (c <= 8) ? 14'h02FD : 14'h0000;
            exp_ready = (c == 4) || (c >= 8);
            exp_cnt   = (c < 5) ? 32'd1 : 32'd2;
            checks++; if (cs_n !== exp_cs) begin errors++; $display("FAIL b2b_cs_n c%0d: got %b expected %b", c, cs_n, exp_cs); end
            checks++; if (ca !== exp_ca) begin errors++; $display("FAIL b2b_ca c%0d: got %h expected %h", c, ca, exp_ca); end
            checks++; if (bus.cmd_ready !== exp_ready) begin errors++; $display("FAIL b2b_ready c%0d: got %b expected %b", c, bus.cmd_ready, exp_ready); end
            checks++; if (cmd_issued !== (c == 1 || c == 5)) begin errors++; $display("FAIL b2b_issued c%0d: got %b expected %b", c, cmd_issued, (c == 1 || c == 5)); end
            checks++; if (issue_count !== exp_cnt) begin errors++; $display("FAIL b2b_count c%0d: got %0d expected %0d", c, issue_count, exp_cnt); end
            if (c == 5) bus.cmd_valid = 1'b0;
            next_cycle();
        end
    endtask

    task automatic test_pre_ref();
        logic        exp_cs;
        logic [13:0] exp_ca;
        logic        exp_ready;
        do_reset();
        drive(1'b1, CMD_PRE, 3'd0, 2'd1, 16'd0, 10'd0);
        next_cycle();
        drive(1'b1, CMD_REF, 3'd7, 2'd3, 16'hFFFF, 10'h3FF);
        for (int c = 1; c <= 5; c++) begin
            exp_cs    = (c == 5);
            exp_ca    = (c <= 2) ? 14'h005B : (c <= 4) ? 14'h0013 : 14'h0000;
            exp_ready = (c == 2) || (c >= 4);
            checks++; if (cs_n !== exp_cs) begin errors++; $display("FAIL preref_cs_n c%0d: got %b expected %b", c, cs_n, exp_cs); end
            checks++; if (ca !== exp_ca) begin errors++; $display("FAIL preref_ca c%0d: got %h expected %h", c, ca, exp_ca); end
            checks++; if (bus.cmd_ready !== exp_ready) begin errors++; $display("FAIL preref_ready c%0d: got %b expected %b", c, bus.cmd_ready, exp_ready); end
            checks++; if (cmd_issued !== (c == 1 || c == 3)) begin errors++; $display("FAIL preref_issued c%0d: got %b expected %b", c, cmd_issued, (c == 1 || c == 3)); end
            if (c == 3) bus.cmd_valid = 1'b0;
            next_cycle();
        end
        checks++; if (issue_count !== 32'd2) begin errors++; $display("FAIL preref_count: got %0d expected 2", issue_count); end
    endtask

    task automatic test_illegal();
        do_reset();
        drive(1'b1, 3'd7, 3'd2, 2'd1, 16'h1234, 10'h155);
        next_cycle();
        bus.cmd_valid = 1'b0;
        checks++; if (err_illegal !== 1'b1) begin errors++; $display("FAIL ill_err_c1: got %b expected 1", err_illegal); end
        checks++; if (cs_n !== 1'b1 || ca !== 14'h0) begin errors++; $display("FAIL ill_bus_c1: got cs_n=%b ca=%h expected cs_n=1 ca=0000", cs_n, ca); end
        checks++; if (issue_count !== 32'd0 || cmd_issued !== 1'b0) begin errors++; $display("FAIL ill_count_c1: got %0d/%b expected 0/0", issue_count, cmd_issued); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL ill_ready_c1: got %b expected 1", bus.cmd_ready); end
        next_cycle();
        checks++; if (err_illegal !== 1'b0 || cs_n !== 1'b1) begin errors++; $display("FAIL ill_c2: got err=%b cs_n=%b expected err=0 cs_n=1", err_illegal, cs_n); end
        drive(1'b1, CMD_NOP, 3'd0, 2'd0, 16'd0, 10'd0);
        next_cycle();
        bus.cmd_valid = 1'b0;
        checks++; if (err_illegal !== 1'b1 || cs_n !== 1'b1) begin errors++; $display("FAIL nop_c1: got err=%b cs_n=%b expected err=1 cs_n=1", err_illegal, cs_n); end
        checks++; if (issue_count !== 32'd0) begin errors++; $display("FAIL nop_count: got %0d expected 0", issue_count); end
    endtask

    task automatic test_reset_mid_ph2();
        do_reset();
        drive(1'b1, CMD_ACT, 3'd5, 2'd2, 16'hABCD, 10'd0);
        next_cycle();
        bus.cmd_valid = 1'b0;
        next_cycle();
        next_cycle();
        checks++; if (cs_n !== 1'b1 || ca !== 14'h0ABC) begin errors++; $display("FAIL mid_ph2: got cs_n=%b ca=%h expected cs_n=1 ca=0abc", cs_n, ca); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (cs_n !== 1'b1 || ca !== 14'h0) begin errors++; $display("FAIL rst_async_bus: got cs_n=%b ca=%h expected cs_n=1 ca=0000", cs_n, ca); end
        checks++; if (bus.cmd_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready: got %b expected 1", bus.cmd_ready); end
        checks++; if (issue_count !== 32'd0) begin errors++; $display("FAIL rst_async_count: got %0d expected 0", issue_count); end
        next_cycle();
        reset_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            checks++; if (cs_n !== 1'b1 || ca !== 14'h0) begin errors++; $display("FAIL rst_after_bus c%0d: got cs_n=%b ca=%h expected cs_n=1 ca=0000", c, cs_n, ca); end
            checks++; if (cmd_issued !== 1'b0) begin errors++; $display("FAIL rst_after_issued c%0d: got %b expected 0", c, cmd_issued); end
            next_cycle();
        end
    endtask

    initial begin
        test_reset();
        test_act();
        test_back_to_back();
        test_pre_ref();
        test_illegal();
        test_reset_mid_ph2();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
